// File: rtl/ko_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : ko_sequencer
// Description : Knock-out banner sequencer. After a KO trigger it freezes
//               player motion, waits DELAY_FRAMES frames, shows the KO banner
//               (blinking when KO_BLINK_EN is defined, steady otherwise) for
//               2*BLINK_FRAMES*BLINK_COUNT frames, then holds the banner for
//               HOLD_FRAMES frames, pulses round_over and waits for restart.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Configuration macro:
//   KO_BLINK_EN  defined   -> banner alternates on/off during SHOW
//                undefined -> banner steady on during SHOW (same timing)
// Ports:
//   Clk          in   system clock, rising edge
//   Reset        in   asynchronous active-high reset
//   frame_clk    in   frame strobe, asynchronous to Clk
//   ko_event     in   KO trigger (honoured only in IDLE)
//   restart      in   return to IDLE (highest priority after Reset)
//   exist_ko     out  banner enable for the overlay stage (registered)
//   game_freeze  out  freeze of player motion (registered)
//   round_over   out  one-cycle end-of-sequence pulse (registered)
// ============================================================================
module ko_sequencer #(
    parameter int DELAY_FRAMES = 30,
    parameter int BLINK_FRAMES = 8,
    parameter int BLINK_COUNT  = 3,
    parameter int HOLD_FRAMES  = 120
) (
    input  logic Clk,
    input  logic Reset,
    input  logic frame_clk,
    input  logic ko_event,
    input  logic restart,
    output logic exist_ko,
    output logic game_freeze,
    output logic round_over
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_DELAY = 3'd1,
        S_SHOW  = 3'd2,
        S_HOLD  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    // Terminal values of the 8-bit counters.
    localparam logic [7:0] C_DELAY_LAST = 8'(DELAY_FRAMES - 1);
    localparam logic [7:0] C_BLINK_LAST = 8'(BLINK_FRAMES - 1);
    localparam logic [7:0] C_HALF_LAST  = 8'(2 * BLINK_COUNT - 1);
    localparam logic [7:0] C_HOLD_LAST  = 8'(HOLD_FRAMES - 1);

    // Frame strobe synchroniser and rising-edge detector.
    logic r_s1;
    logic r_s2;
    logic w_tick;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_cnt;
    logic [7:0] w_cnt_nxt;
    logic [7:0] r_half;
    logic [7:0] w_half_nxt;
    logic [7:0] w_half_inc;
    logic       r_exist;
    logic       w_exist_nxt;
    logic       r_freeze;
    logic       w_freeze_nxt;
    logic       r_round_over;
    logic       w_round_over_nxt;
    logic       w_show_on;

    assign w_tick     = r_s1 & ~r_s2;
    assign w_half_inc = r_half + 8'd1;

    // Banner level for the half-period being entered: even index on, odd off.
`ifdef KO_BLINK_EN
    assign w_show_on = ~w_half_inc[0];
`else
    assign w_show_on = 1'b1;
`endif

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_s1         <= 1'b0;
            r_s2         <= 1'b0;
            r_state      <= S_IDLE;
            r_cnt        <= 8'd0;
            r_half       <= 8'd0;
            r_exist      <= 1'b0;
            r_freeze     <= 1'b0;
            r_round_over <= 1'b0;
        end else begin
            r_s1         <= frame_clk;
            r_s2         <= r_s1;
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_half       <= w_half_nxt;
            r_exist      <= w_exist_nxt;
            r_freeze     <= w_freeze_nxt;
            r_round_over <= w_round_over_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_half_nxt       = r_half;
        w_exist_nxt      = r_exist;
        w_freeze_nxt     = r_freeze;
        w_round_over_nxt = 1'b0;

        if (restart) begin
            w_state_nxt  = S_IDLE;
            w_cnt_nxt    = 8'd0;
            w_half_nxt   = 8'd0;
            w_exist_nxt  = 1'b0;
            w_freeze_nxt = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_exist_nxt  = 1'b0;
                    w_freeze_nxt = 1'b0;
                    if (ko_event) begin
                        w_state_nxt  = S_DELAY;
                        w_cnt_nxt    = 8'd0;
                        w_half_nxt   = 8'd0;
                        w_freeze_nxt = 1'b1;
                    end
                end
                S_DELAY: begin
                    if (w_tick) begin
                        if (r_cnt == C_DELAY_LAST) begin
                            w_state_nxt = S_SHOW;
                            w_cnt_nxt   = 8'd0;
                            w_half_nxt  = 8'd0;
                            w_exist_nxt = 1'b1;
                        end else begin
                            w_cnt_nxt = r_cnt + 8'd1;
                        end
                    end
                end
                S_SHOW: begin
                    if (w_tick) begin
                        if (r_cnt == C_BLINK_LAST) begin
                            w_cnt_nxt = 8'd0;
                            if (r_half == C_HALF_LAST) begin
                                // Last frame of the final off half-period.
                                w_state_nxt = S_HOLD;
                                w_half_nxt  = 8'd0;
                                w_exist_nxt = 1'b1;
                            end else begin
                                w_half_nxt  = w_half_inc;
                                w_exist_nxt = w_show_on;
                            end
                        end else begin
                            w_cnt_nxt = r_cnt + 8'd1;
                        end
                    end
                end
                S_HOLD: begin
                    w_exist_nxt = 1'b1;
                    if (w_tick) begin
                        if (r_cnt == C_HOLD_LAST) begin
                            w_state_nxt      = S_DONE;
                            w_cnt_nxt        = 8'd0;
                            w_round_over_nxt = 1'b1;
                        end else begin
                            w_cnt_nxt = r_cnt + 8'd1;
                        end
                    end
                end
                S_DONE: begin
                    w_exist_nxt  = 1'b1;
                    w_freeze_nxt = 1'b1;
                end
                default: begin
                    w_state_nxt  = S_IDLE;
                    w_cnt_nxt    = 8'd0;
                    w_half_nxt   = 8'd0;
                    w_exist_nxt  = 1'b0;
                    w_freeze_nxt = 1'b0;
                end
            endcase
        end
    end

    assign exist_ko    = r_exist;
    assign game_freeze = r_freeze;
    assign round_over  = r_round_over;

endmodule
`default_nettype wire

// File: tb/tb_ko_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_ko_sequencer
// Description : Self-checking bench for ko_sequencer with default parameters.
//               Expected banner level is computed from the number of frames
//               elapsed since the KO trigger.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ko_sequencer;

    localparam int DF = 30;
    localparam int BF = 8;
    localparam int BC = 3;
    localparam int HF = 120;
    localparam int SHOW_END = DF + 2 * BF * BC;
    localparam int SEQ_END  = SHOW_END + HF;

    logic Clk = 1'b0;
    logic Reset;
    logic frame_clk;
    logic ko_event;
    logic restart;
    logic exist_ko;
    logic game_freeze;
    logic round_over;

    int checks   = 0;
    int failures = 0;
    int ro_cnt   = 0;
    int ro_base  = 0;

    ko_sequencer #(
        .DELAY_FRAMES (DF),
        .BLINK_FRAMES (BF),
        .BLINK_COUNT  (BC),
        .HOLD_FRAMES  (HF)
    ) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .frame_clk   (frame_clk),
        .ko_event    (ko_event),
        .restart     (restart),
        .exist_ko    (exist_ko),
        .game_freeze (game_freeze),
        .round_over  (round_over)
    );

    always #5 Clk = ~Clk;

    // Counts every Clk cycle in which round_over is high.
    always @(posedge Clk) begin
        #1;
        if (round_over === 1'b1) ro_cnt = ro_cnt + 1;
    end

    // Banner level after k frames since the KO trigger.
    function automatic logic exp_exist(int k);
        if (k < DF) return 1'b0;
        if (k < SHOW_END) begin
`ifdef KO_BLINK_EN
            return (((k - DF) / BF) % 2) == 0;
`else
            return 1'b1;
`endif
        end
        return 1'b1;
    endfunction

    // One frame strobe of random width; optionally a stray ko_event.
    task automatic frame_tick(input bit inject);
        @(negedge Clk);
        frame_clk = 1'b1;
        repeat ($urandom_range(1, 4)) @(negedge Clk);
        frame_clk = 1'b0;
        if (inject && ($urandom_range(0, 2) == 0)) begin
            ko_event = 1'b1;
            @(negedge Clk);
            ko_event = 1'b0;
        end
        repeat ($urandom_range(3, 5)) @(negedge Clk);
    endtask

    task automatic pulse_ko();
        @(negedge Clk);
        ko_event = 1'b1;
        @(negedge Clk);
        ko_event = 1'b0;
    endtask

    task automatic do_restart();
        @(negedge Clk);
        restart = 1'b1;
        @(negedge Clk);
        restart = 1'b0;
    endtask

    task automatic check_frame(input string tag, input int k);
        logic exp_ro;
        exp_ro = (k >= SEQ_END);
        checks = checks + 1;
        if (exist_ko !== exp_exist(k)) begin
            failures = failures + 1;
            $display("FAIL %s exist_ko frame=%0d got=%b want=%b", tag, k, exist_ko, exp_exist(k));
        end
        checks = checks + 1;
        if (game_freeze !== 1'b1) begin
            failures = failures + 1;
            $display("FAIL %s game_freeze frame=%0d got=%b want=1", tag, k, game_freeze);
        end
        checks = checks + 1;
        if ((ro_cnt - ro_base) != int'(exp_ro)) begin
            failures = failures + 1;
            $display("FAIL %s round_over_cycles frame=%0d got=%0d want=%0d", tag, k, ro_cnt - ro_base, exp_ro);
        end
    endtask

    task automatic check_idle(input string tag);
        checks = checks + 1;
        if ({exist_ko, game_freeze, round_over} !== 3'b000) begin
            failures = failures + 1;
            $display("FAIL %s idle_outputs got=%b%b%b want=000", tag, exist_ko, game_freeze, round_over);
        end
    endtask

    task automatic run_sequence(input string tag, input bit inject, input int nframes);
        ro_base = ro_cnt;
        pulse_ko();
        check_frame(tag, 0);
        for (int k = 1; k <= nframes; k++) begin
            frame_tick(inject);
            check_frame(tag, k);
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1; frame_clk = 1'b0; ko_event = 1'b0; restart = 1'b0;
        repeat (3) @(negedge Clk);
        check_idle("reset_active");
        Reset = 1'b0;
        @(negedge Clk);
        check_idle("reset_released");
    endtask

    task automatic test_idle_frames();
        for (int i = 0; i < 4; i++) begin
            frame_tick(1'b0);
            check_idle("idle_frames");
        end
    endtask

    task automatic test_full_sequence();
        run_sequence("full", 1'b0, SEQ_END + 6);
        do_restart();
        check_idle("full_restart");
    endtask

    task automatic test_ko_ignored();
        run_sequence("ko_ignored", 1'b1, SEQ_END + 3);
        do_restart();
        check_idle("ko_ignored_restart");
    endtask

    task automatic test_restart_show();
        run_sequence("pre_restart", 1'b0, DF + 3 * BF + 3);
        do_restart();
        check_idle("restart_in_show");
        frame_tick(1'b0);
        check_idle("restart_in_show_frame");
        run_sequence("replay", 1'b0, SEQ_END + 2);
        do_restart();
    endtask

    task automatic test_restart_with_ko();
        @(negedge Clk);
        restart = 1'b1; ko_event = 1'b1;
        @(negedge Clk);
        restart = 1'b0; ko_event = 1'b0;
        check_idle("restart_ko_idle");
        for (int i = 0; i < DF + 2; i++) frame_tick(1'b0);
        check_idle("restart_ko_idle_frames");
    endtask

    task automatic test_async_reset();
        run_sequence("pre_reset", 1'b0, 10);
        @(posedge Clk);
        #3;
        Reset = 1'b1;
        #1;
        check_idle("async_reset");
        @(negedge Clk);
        Reset = 1'b0;
        for (int i = 0; i < DF + 4; i++) frame_tick(1'b0);
        check_idle("after_reset_frames");
    endtask

    task automatic test_long_frame();
        ro_base = ro_cnt;
        pulse_ko();
        @(negedge Clk);
        frame_clk = 1'b1;
        repeat (1000) @(negedge Clk);
        frame_clk = 1'b0;
        repeat (3) @(negedge Clk);
        check_frame("long_frame", 1);
        for (int k = 2; k <= DF + 2; k++) begin
            frame_tick(1'b0);
            check_frame("long_frame", k);
        end
        do_restart();
    endtask

    initial begin
        test_reset();
        test_idle_frames();
        test_full_sequence();
        test_ko_ignored();
        test_restart_show();
        test_restart_with_ko();
        test_async_reset();
        test_long_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ko_sequencer.md
KO_SEQUENCER -- requirements
Module: ko_sequencer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; it SHALL expose the parameters and ports in REQ-002 to REQ-011.
REQ-002 Parameter DELAY_FRAMES, default 30: frames from KO trigger to first banner display; legal range 1..255.
REQ-003 Parameter BLINK_FRAMES, default 8: frames per blink half-period; legal range 1..255.
REQ-004 Parameter BLINK_COUNT, default 3: number of on/off blink pairs; legal range 1..127.
REQ-005 Parameter HOLD_FRAMES, default 120: frames of steady banner before round end; legal range 1..255.
REQ-006 Clk  input  1: system clock; every register SHALL be clocked on its rising edge.
REQ-007 Reset  input  1: asynchronous, active-high reset.
REQ-008 frame_clk  input  1: vertical-sync-rate frame strobe; asynchronous to Clk.
REQ-009 ko_event, restart  input  1 each: KO trigger from game logic; return to idle from game logic.
REQ-010 exist_ko  output  1: banner enable for the KO overlay stage.
REQ-011 game_freeze  output  1, round_over  output  1: freeze of player motion; one-cycle end-of-sequence pulse.

Function
REQ-012 frame_clk SHALL pass through two Clk flops (s1, s2); the internal tick SHALL be s1 AND NOT s2, high for exactly one Clk cycle per frame_clk rising edge, regardless of how long frame_clk stays high.
REQ-013 The FSM SHALL have the states IDLE, DELAY, SHOW, HOLD and DONE; every output SHALL be registered.
REQ-014 IDLE: exist_ko=0 and game_freeze=0; ko_event=1 on a Clk edge SHALL move the FSM to DELAY, clear the frame counter, and set game_freeze=1 on that edge.
REQ-015 DELAY: each tick SHALL increment the frame counter; a tick with counter==DELAY_FRAMES-1 SHALL move the FSM to SHOW, clear the counters and set exist_ko=1 on that edge.
REQ-016 SHOW: a half-period index SHALL run 0..2*BLINK_COUNT-1, advancing after every BLINK_FRAMES ticks; exist_ko SHALL be 1 for even indices and 0 for odd indices.
REQ-017 SHOW SHALL last exactly 2*BLINK_FRAMES*BLINK_COUNT ticks; the final tick SHALL move the FSM to HOLD with exist_ko=1.
REQ-018 HOLD: exist_ko=1; a tick with counter==HOLD_FRAMES-1 SHALL move the FSM to DONE and assert round_over for exactly one Clk cycle.
REQ-019 DONE: exist_ko=1 and game_freeze=1 SHALL be held until restart.
REQ-020 restart=1 in any state SHALL, on the next Clk edge, move the FSM to IDLE and clear the counters, exist_ko, game_freeze and round_over.
REQ-021 restart SHALL take priority over ko_event and over a tick in the same cycle.
REQ-022 ko_event outside IDLE SHALL be ignored and SHALL leave the sequence timing unchanged.
REQ-023 Counters SHALL be 8 bits wide; the half-period index SHALL be 8 bits wide.
REQ-024 Counters SHALL never wrap within legal parameter ranges.
REQ-025 Reaching a terminal count in one state SHALL always clear the counter.

Reset
REQ-026 Reset=1 SHALL immediately, without a Clk edge, force the state to IDLE and set the counters, s1, s2, exist_ko, game_freeze and round_over to 0.
REQ-027 Reset SHALL take priority over every other input, in every state.
REQ-028 After Reset deasserts, the block SHALL begin from IDLE; any KO sequence that was in progress SHALL be abandoned.

Configuration
REQ-029 With macro KO_BLINK_EN defined, SHOW SHALL blink as in REQ-016.
REQ-030 With KO_BLINK_EN undefined, exist_ko SHALL be 1 throughout SHOW; SHOW duration, HOLD duration and all other behaviour SHALL be identical to the blinking build.

Verification
REQ-031 Defaults, KO_BLINK_EN on, ko_event pulse -> exist_ko=0 for 30 ticks, then 1/0 in 8-tick halves three times (48 ticks), then 1 for 120 ticks; one round_over pulse after tick 198; exist_ko stays 1.
REQ-032 Defaults, KO_BLINK_EN off -> exist_ko rises after tick 30 and stays 1; round_over fires after tick 198.
REQ-033 restart during SHOW half-period 3 -> all outputs 0 on the next edge; a fresh ko_event replays the full 30/48/120 timeline.
REQ-034 ko_event pulses during DELAY and HOLD -> timeline identical to REQ-031; restart and ko_event together in IDLE -> FSM stays IDLE.
REQ-035 Reset asserted mid-DELAY between Clk edges -> game_freeze=0 and exist_ko=0 before the next Clk edge.
REQ-036 frame_clk held high for 1000 Clk cycles -> exactly one tick counted.
